mult_div_unit: RTL

- HI/LO multiply/divide unit that sits in the EX stage of the 5-stage MIPS pipeline.
- It is the producer side of the start/Busy interface that the hazard unit consumes. The hazard unit stalls D-stage MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO while start or busy is high.
- It accepts operands from EX-stage forwarding, models a fixed multi-cycle latency, and holds the architectural HI/LO registers read by MFHI/MFLO.

---
 rtl/md_pkg.sv | 31 +++
 rtl/mult_div_unit_if.sv | 23 ++
 rtl/md_arith.sv | 54 +++++
 rtl/mult_div_unit.sv | 87 ++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// Covers operation encodings, FSM states, counter width and op-class helpers.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int MD_CNT_W = 4;
  typedef logic [MD_CNT_W-1:0] md_cnt_t;

  function automatic logic is_div_op(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Only these four ops launch a multi-cycle operation; MTHI/MTLO never do.
  function automatic logic is_md_op(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || is_div_op(op);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// EX-stage <-> multiply/divide unit bundle: operation request in, busy and HI/LO out.
interface mult_div_unit_if;
  import md_pkg::*;

  logic        start;
  md_op_e      md_op;
  logic        we_hilo;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, we_hilo, rs_val, rt_val,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, we_hilo, rs_val, rt_val,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_arith.sv
// Combinational 32x32 multiply and divide datapath producing the pending HI/LO pair.
// Signedness is chosen by md_op; the FSM in the top decides when results commit.
module md_arith
  import md_pkg::*;
(
  input  md_op_e      md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] phi,
  output logic [31:0] plo,
  output logic        div_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               rt_zero;
  logic               div_ovf;
  logic        [31:0] divisor;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Divisor is steered away from 0 and from -1 on the INT_MIN overflow case;
  // dividing INT_MIN by 1 then yields exactly the required lo=0x80000000, hi=0.
  assign rt_zero = (rt_val == 32'd0);
  assign div_ovf = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
  assign divisor = (rt_zero || div_ovf) ? 32'd1 : rt_val;

  assign quo_s = $signed(rs_val) / $signed(divisor);
  assign rem_s = $signed(rs_val) % $signed(divisor);
  assign quo_u = rs_val / divisor;
  assign rem_u = rs_val % divisor;

  assign div_zero = is_div_op(md_op) && rt_zero;

  // NOTE: every output of a combinational block gets a default first so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    phi = 32'd0;
    plo = 32'd0;
    unique case (md_op)
      MD_MULT:  {phi, plo} = prod_s;
      MD_MULTU: {phi, plo} = prod_u;
      MD_DIV:   begin phi = rem_s; plo = quo_s; end
      MD_DIVU:  begin phi = rem_u; plo = quo_u; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage HI/LO multiply/divide unit: fixed-latency busy window, result committed
// to the architectural HI/LO registers on the edge busy falls.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic            clk,
  input logic            reset_n,
  mult_div_unit_if.slave md
);

  md_state_e   state;
  md_cnt_t     cnt;
  logic [31:0] phi_q;
  logic [31:0] plo_q;
  logic        zero_q;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] phi;
  logic [31:0] plo;
  logic        div_zero;

  md_arith u_arith (
    .md_op    (md.md_op),
    .rs_val   (md.rs_val),
    .rt_val   (md.rt_val),
    .phi      (phi),
    .plo      (plo),
    .div_zero (div_zero)
  );

  // Operands are consumed only in the launch cycle; the pending pair is latched
  // then, so later changes on the forwarding paths cannot disturb the result.
  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      phi_q  <= '0;
      plo_q  <= '0;
      zero_q <= 1'b0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      unique case (state)
        MD_IDLE: begin
          if (md.start) begin
            if (is_md_op(md.md_op)) begin
              state  <= MD_RUN;
              busy_q <= 1'b1;
              cnt    <= is_div_op(md.md_op) ? md_cnt_t'(DIV_CYCLES) : md_cnt_t'(MULT_CYCLES);
              phi_q  <= phi;
              plo_q  <= plo;
              zero_q <= div_zero;
            end
          end else if (md.we_hilo) begin
            if (md.md_op == MD_MTHI) hi_q <= md.rs_val;
            if (md.md_op == MD_MTLO) lo_q <= md.rs_val;
          end
        end
        MD_RUN: begin
          cnt <= cnt - md_cnt_t'(1);
          if (cnt == md_cnt_t'(1)) begin
            state  <= MD_IDLE;
            busy_q <= 1'b0;
            if (!zero_q) begin
              hi_q <= phi_q;
              lo_q <= plo_q;
            end
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
